// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: multi-digit code lock with failed-attempt counting,
// timed lockout, timed unlock pulse and in-place reprogramming of the code.
module code_lock_ctrl #(
  parameter int DIGIT_W        = 7,
  parameter int CODE_LEN       = 4,
  parameter int MAX_TRIES      = 3,
  parameter int UNLOCK_CYCLES  = 8,
  parameter int LOCKOUT_CYCLES = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {7'd1, 7'd2, 7'd3, 7'd4}
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DIGIT_W-1:0]                digit_in,
  input  logic                              digit_valid,
  input  logic                              clear,
  input  logic                              prog_req,
  output logic                              unlocked,
  output logic                              lockout,
  output logic                              error,
  output logic                              prog_done,
  output logic [$clog2(MAX_TRIES+1)-1:0]    attempts_left,
  output logic [$clog2(CODE_LEN+1)-1:0]     digit_cnt
);

  localparam int BW   = CODE_LEN * DIGIT_W;
  localparam int AW   = $clog2(MAX_TRIES + 1);
  localparam int CW   = $clog2(CODE_LEN + 1);
  localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_OPEN,
    S_PROG,
    S_LOCKOUT
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_timer;
  logic [BW-1:0]   r_buf;
  logic [BW-1:0]   r_code;
  logic [BW-1:0]   w_digitExt;
  logic [BW-1:0]   w_nextBuf;
  logic            w_lastDigit;

  // Entry buffer shifted left by one digit with the new digit appended at the
  // bottom, so the first digit entered ends up most significant.
  always_comb begin
    w_digitExt  = BW'(digit_in);
    w_nextBuf   = (r_buf << DIGIT_W) | w_digitExt;
    w_lastDigit = (digit_cnt == CW'(CODE_LEN - 1));
  end

  // Main controller: state, timer, buffers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_buf         <= '0;
      r_code        <= DEFAULT_CODE;
      unlocked      <= 1'b0;
      lockout       <= 1'b0;
      error         <= 1'b0;
      prog_done     <= 1'b0;
      attempts_left <= AW'(MAX_TRIES);
      digit_cnt     <= '0;
    end else begin
      error     <= 1'b0;
      prog_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            digit_cnt <= '0;
          end else if (digit_valid) begin
            r_buf <= w_nextBuf;
            if (w_lastDigit) begin
              digit_cnt <= '0;
              r_state   <= S_CHECK;
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
            end
          end
        end

        S_CHECK: begin
          if (r_buf == r_code) begin
            r_state       <= S_OPEN;
            r_timer       <= TW'(UNLOCK_CYCLES);
            attempts_left <= AW'(MAX_TRIES);
            unlocked      <= 1'b1;
          end else begin
            error <= 1'b1;
            if (attempts_left <= AW'(1)) begin
              attempts_left <= '0;
              r_state       <= S_LOCKOUT;
              r_timer       <= TW'(LOCKOUT_CYCLES);
              lockout       <= 1'b1;
            end else begin
              attempts_left <= attempts_left - AW'(1);
              r_state       <= S_IDLE;
            end
          end
        end

        S_OPEN: begin
          if (prog_req) begin
            r_state   <= S_PROG;
            unlocked  <= 1'b0;
            digit_cnt <= '0;
          end else if (r_timer == TW'(1)) begin
            r_state  <= S_IDLE;
            unlocked <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        S_PROG: begin
          if (clear) begin
            digit_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (digit_valid) begin
            r_buf <= w_nextBuf;
            if (w_lastDigit) begin
              r_code    <= w_nextBuf;
              prog_done <= 1'b1;
              digit_cnt <= '0;
              r_state   <= S_IDLE;
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
            end
          end
        end

        S_LOCKOUT: begin
          if (r_timer == TW'(1)) begin
            r_state       <= S_IDLE;
            lockout       <= 1'b0;
            attempts_left <= AW'(MAX_TRIES);
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: directed self-checking bench for code_lock_ctrl with
// default parameters.
module tb_code_lock_ctrl;

  logic       clk;
  logic       rst;
  logic [6:0] digit_in;
  logic       digit_valid;
  logic       clear;
  logic       prog_req;
  logic       unlocked;
  logic       lockout;
  logic       error;
  logic       prog_done;
  logic [1:0] attempts_left;
  logic [2:0] digit_cnt;

  int checks   = 0;
  int failures = 0;

  code_lock_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .digit_in      (digit_in),
    .digit_valid   (digit_valid),
    .clear         (clear),
    .prog_req      (prog_req),
    .unlocked      (unlocked),
    .lockout       (lockout),
    .error         (error),
    .prog_done     (prog_done),
    .attempts_left (attempts_left),
    .digit_cnt     (digit_cnt)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendDigit(input logic [6:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [6:0] a, input logic [6:0] b,
                               input logic [6:0] c, input logic [6:0] d);
    sendDigit(a);
    sendDigit(b);
    sendDigit(c);
    sendDigit(d);
  endtask

  // Counts consecutive cycles with unlocked high, starting at the current sample.
  task automatic measureUnlock(input string tag, input int expected);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 40 && unlocked; i++) begin
      cnt++;
      tick();
    end
    checkOutput(tag, cnt, expected);
  endtask

  initial begin
    int cnt;
    rst         = 1'b1;
    digit_in    = '0;
    digit_valid = 1'b0;
    clear       = 1'b0;
    prog_req    = 1'b0;
    #2;
    checkOutput("rstUnlocked", unlocked, 0);
    checkOutput("rstLockout", lockout, 0);
    checkOutput("rstError", error, 0);
    checkOutput("rstProgDone", prog_done, 0);
    checkOutput("rstAttempts", attempts_left, 3);
    checkOutput("rstDigitCnt", digit_cnt, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Correct code
    sendDigit(7'd1);
    checkOutput("cnt1", digit_cnt, 1);
    sendDigit(7'd2);
    sendDigit(7'd3);
    checkOutput("cnt3", digit_cnt, 3);
    sendDigit(7'd4);
    checkOutput("checkNotYetOpen", unlocked, 0);
    checkOutput("cntWrap", digit_cnt, 0);
    tick();
    checkOutput("okUnlocked", unlocked, 1);
    checkOutput("okNoError", error, 0);
    checkOutput("okAttempts", attempts_left, 3);
    measureUnlock("okUnlockLen", 8);

    // Wrong code three times then lockout
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd5);
    tick();
    checkOutput("wrong1Error", error, 1);
    checkOutput("wrong1Attempts", attempts_left, 2);
    checkOutput("wrong1Unlocked", unlocked, 0);
    tick();
    checkOutput("errorOneCycle", error, 0);
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd5);
    tick();
    checkOutput("wrong2Error", error, 1);
    checkOutput("wrong2Attempts", attempts_left, 1);
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd5);
    tick();
    checkOutput("wrong3Error", error, 1);
    checkOutput("wrong3Attempts", attempts_left, 0);
    checkOutput("wrong3Lockout", lockout, 1);
    cnt = 1;
    for (int i = 0; i < 60 && lockout; i++) begin
      digit_valid = (cnt < 6);
      digit_in    = 7'(cnt);
      clear       = (cnt == 8);
      prog_req    = (cnt == 9);
      tick();
      if (lockout) cnt++;
    end
    digit_valid = 1'b0;
    clear       = 1'b0;
    prog_req    = 1'b0;
    checkOutput("lockoutLen", cnt, 16);
    checkOutput("postLockAttempts", attempts_left, 3);
    checkOutput("postLockDigitCnt", digit_cnt, 0);
    checkOutput("postLockUnlocked", unlocked, 0);
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd4);
    tick();
    checkOutput("postLockOpen", unlocked, 1);
    measureUnlock("postLockUnlockLen", 8);

    // Clear beats digit_valid in the same cycle
    sendDigit(7'd1);
    sendDigit(7'd2);
    checkOutput("preClearCnt", digit_cnt, 2);
    clear       = 1'b1;
    digit_valid = 1'b1;
    digit_in    = 7'd3;
    tick();
    clear       = 1'b0;
    digit_valid = 1'b0;
    checkOutput("clearCnt", digit_cnt, 0);
    tick();
    checkOutput("clearNoError", error, 0);
    checkOutput("clearAttempts", attempts_left, 3);
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd4);
    tick();
    checkOutput("clearThenOpen", unlocked, 1);
    measureUnlock("clearUnlockLen", 8);

    // Reprogram to 9,8,7,6
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd4);
    tick();
    checkOutput("progOpen", unlocked, 1);
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    checkOutput("progUnlockedLow", unlocked, 0);
    applyStimulus(7'd9, 7'd8, 7'd7, 7'd6);
    checkOutput("progDone", prog_done, 1);
    tick();
    checkOutput("progDoneOneCycle", prog_done, 0);
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd4);
    tick();
    checkOutput("oldCodeError", error, 1);
    checkOutput("oldCodeAttempts", attempts_left, 2);
    applyStimulus(7'd9, 7'd8, 7'd7, 7'd6);
    tick();
    checkOutput("newCodeOpen", unlocked, 1);
    checkOutput("newCodeAttempts", attempts_left, 3);
    measureUnlock("newCodeUnlockLen", 8);

    // Reset in the middle of programming
    applyStimulus(7'd9, 7'd8, 7'd7, 7'd6);
    tick();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
    sendDigit(7'd5);
    sendDigit(7'd5);
    checkOutput("midProgCnt", digit_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midRstUnlocked", unlocked, 0);
    checkOutput("midRstProgDone", prog_done, 0);
    checkOutput("midRstAttempts", attempts_left, 3);
    checkOutput("midRstDigitCnt", digit_cnt, 0);
    tick();
    rst = 1'b0;
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd4);
    tick();
    checkOutput("rstDefaultOpen", unlocked, 1);
    measureUnlock("rstUnlockLen", 8);

    // Recovery after two failures
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd5);
    tick();
    applyStimulus(7'd4, 7'd3, 7'd2, 7'd1);
    tick();
    checkOutput("recoverAttempts1", attempts_left, 1);
    checkOutput("recoverNoLockout", lockout, 0);
    applyStimulus(7'd1, 7'd2, 7'd3, 7'd4);
    tick();
    checkOutput("recoverOpen", unlocked, 1);
    checkOutput("recoverAttempts", attempts_left, 3);
    measureUnlock("recoverUnlockLen", 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Parametrised successor to the single-digit password checker in the door-lock (fechadura) design. It accepts a multi-digit code one digit at a time, typically from the processor's parallel output port, and compares it against a stored, reprogrammable code. It counts failed attempts and enforces a timed lockout after too many failures. It produces a timed unlock pulse that drives the lock LEDs/LCD status logic.

## Interface
- DIGIT_W, 7: width of one code digit.
- CODE_LEN, 4: digits per code, ≥1.
- MAX_TRIES, 3: consecutive failures before lockout, ≥1.
- UNLOCK_CYCLES, 8: cycles `unlocked` stays high after a match, ≥1.
- LOCKOUT_CYCLES, 16: cycles spent in lockout, ≥1.
- DEFAULT_CODE, {7'd1,7'd2,7'd3,7'd4}: reset code (CODE_LEN*DIGIT_W bits); the most significant digit is entered first.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- digit_in  in  DIGIT_W  digit value, sampled when digit_valid=1.
- digit_valid  in  1  one-cycle strobe, one digit per high cycle.
- clear  in  1  discard partially entered digits.
- prog_req  in  1  request a code change; honoured only while unlocked.
- unlocked  out  1  high during the OPEN state.
- lockout  out  1  high during the LOCKOUT state.
- error  out  1  one-cycle pulse on a mismatch.
- prog_done  out  1  one-cycle pulse when a new code is stored.
- attempts_left  out  $clog2(MAX_TRIES+1)  remaining tries.
- digit_cnt  out  $clog2(CODE_LEN+1)  digits buffered in the current entry.

## Operation
- States: IDLE, CHECK, OPEN, PROG, LOCKOUT.
- Reset state:
  - state=IDLE, stored code=DEFAULT_CODE, attempts_left=MAX_TRIES, digit_cnt=0.
  - unlocked, lockout, error and prog_done all 0.
- IDLE, digit entry:
  - digit_valid shifts digit_in into the entry buffer and increments digit_cnt.
  - When the CODE_LEN-th digit is accepted, digit_cnt returns to 0 and the state goes to CHECK.
- CHECK lasts one cycle and compares the full buffer against the stored code.
  - Match: go to OPEN, load the timer with UNLOCK_CYCLES, set attempts_left=MAX_TRIES.
  - Mismatch with attempts_left>1: pulse error, decrement attempts_left, return to IDLE.
  - Mismatch with attempts_left==1: pulse error, set attempts_left=0, go to LOCKOUT, load the timer with LOCKOUT_CYCLES.
- OPEN:
  - The timer decrements each cycle; the state returns to IDLE when it would reach 0.
  - digit_valid is ignored.
  - prog_req=1 goes to PROG immediately, including on the last OPEN cycle.
- PROG:
  - Digits are entered exactly as in IDLE.
  - On the CODE_LEN-th digit the buffer is written to the stored code, prog_done pulses, and the state goes to IDLE.
  - unlocked=0 while in PROG.
- LOCKOUT:
  - All digit_valid, clear and prog_req inputs are ignored.
  - After LOCKOUT_CYCLES cycles: go to IDLE, set attempts_left=MAX_TRIES.
- clear in IDLE or PROG sets digit_cnt=0 and does not consume an attempt.
  - If clear and digit_valid are high in the same cycle, clear wins and the digit is dropped.
  - A clear in PROG also aborts programming: return to IDLE and keep the old code.
- The comparison is exact over all CODE_LEN*DIGIT_W bits. No wrap-around: digit_cnt never exceeds CODE_LEN-1 while it is observable.
- rst asserted mid-operation, including mid-PROG, restores the full reset state. The stored code reverts to DEFAULT_CODE.

## Timing
- Last digit accepted at edge k: CHECK is entered at k.
- unlocked=1 or error=1 becomes visible after edge k+1, i.e. 1-cycle compare latency.
- unlocked is high for exactly UNLOCK_CYCLES consecutive cycles unless prog_req cuts it short.
- lockout is high for exactly LOCKOUT_CYCLES consecutive cycles.
- attempts_left shows MAX_TRIES from the first IDLE cycle after lockout.
- error and prog_done are high for exactly one cycle, registered.
- All outputs are registered. Reset acts on outputs immediately, with no clock required.

## Test plan
All scenarios use the default parameters.
- Correct code: enter 1,2,3,4 -> unlocked=1 for exactly 8 cycles starting 1 cycle after the 4th digit; attempts_left stays 3.
- Wrong code: enter 1,2,3,5 three times -> error pulses, attempts_left goes 2,1,0; lockout=1 for 16 cycles. Digits entered during lockout are ignored. Afterwards attempts_left=3 and 1,2,3,4 unlocks.
- Clear: enter 1,2, then clear and digit_valid in the same cycle -> digit_cnt=0, no error, attempts_left=3; then 1,2,3,4 unlocks.
- Reprogram: unlock, assert prog_req, enter 9,8,7,6 -> prog_done pulse. Then 1,2,3,4 gives error and 9,8,7,6 unlocks.
- Reset mid-PROG: after 2 new digits, assert rst -> all outputs 0, attempts_left=3, and 1,2,3,4 unlocks.
- Recovery after a partial failure: two wrong entries (attempts_left=1), then the correct code -> unlocked=1 and attempts_left=3.
